id_mex_pipe: RTL

ID/MEX pipeline register of the 8-bit pipelined CPU. Captures the decoded instruction and register-file operands at the end of ID and presents them to MEX. It also computes the operand-select codes for the two ALU operand muxes (`fwd_unit_selector1`, `fwd_unit_selector2`) at capture time, so that they arrive registered alongside the data they steer. Supports global hold, flush-to-bubble, and a saturating forwarding-event counter.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fwd_detect.sv | 37 +++
 rtl/id_mex_pipe.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU operand-select encodings and
// small helpers used by the pipeline registers and operand muxes.
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int IMM_W     = 4;
  localparam int RIDX_W    = 2;
  localparam int OP_W      = 4;
  localparam int FWD_CNT_W = 16;

  localparam logic       SEL1_REG = 1'b0;
  localparam logic       SEL1_FWD = 1'b1;
  localparam logic [1:0] SEL2_REG = 2'b00;
  localparam logic [1:0] SEL2_FWD = 2'b01;
  localparam logic [1:0] SEL2_IMM = 2'b10;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'b00,
    ACT_HOLD   = 2'b01,
    ACT_BUBBLE = 2'b10
  } pipe_act_e;

  function automatic logic [FWD_CNT_W-1:0] sat_inc(input logic [FWD_CNT_W-1:0] v);
    return (v == {FWD_CNT_W{1'b1}}) ? v : v + {{(FWD_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fwd_detect.sv
// Combinational hazard check of the instruction in ID against the one
// currently in ID/MEX; yields the operand-select codes to be registered.
module fwd_detect
  import cpu_pkg::*;
#(
  parameter int RIDX_W = cpu_pkg::RIDX_W
) (
  input  logic              ex_valid_i,
  input  logic              ex_reg_write_i,
  input  logic [RIDX_W-1:0] ex_rd_i,
  input  logic [RIDX_W-1:0] rs1_i,
  input  logic [RIDX_W-1:0] rs2_i,
  input  logic              use_imm_i,
  output logic              sel1_o,
  output logic [1:0]        sel2_o,
  output logic              fwd_event_o
);

  logic hit1_s;
  logic hit2_s;

  always_comb begin
    hit1_s      = ex_valid_i & ex_reg_write_i & (ex_rd_i == rs1_i);
    hit2_s      = ex_valid_i & ex_reg_write_i & (ex_rd_i == rs2_i);
    sel1_o      = hit1_s ? SEL1_FWD : SEL1_REG;
    // The immediate wins over a register hit on operand 2.
    if (use_imm_i) begin
      sel2_o = SEL2_IMM;
    end else if (hit2_s) begin
      sel2_o = SEL2_FWD;
    end else begin
      sel2_o = SEL2_REG;
    end
    fwd_event_o = (sel1_o == SEL1_FWD) | (sel2_o == SEL2_FWD);
  end

endmodule

// File: rtl/id_mex_pipe.sv
// ID/MEX pipeline register: captures decoded instruction and operands,
// registers the ALU operand selectors and counts forwarding events.
module id_mex_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int IMM_W  = cpu_pkg::IMM_W,
  parameter int RIDX_W = cpu_pkg::RIDX_W,
  parameter int OP_W   = cpu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic [DATA_W-1:0] id_reg1,
  input  logic [DATA_W-1:0] id_reg2,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_use_imm,
  input  logic              id_reg_write,
  input  logic              pipe_hold,
  input  logic              pipe_flush,
  output logic              id_mex_valid,
  output logic              id_mex_reg_write,
  output logic [OP_W-1:0]   id_mex_opcode,
  output logic [RIDX_W-1:0] id_mex_rd,
  output logic [DATA_W-1:0] id_mex_reg1,
  output logic [DATA_W-1:0] id_mex_reg2,
  output logic [IMM_W-1:0]  instr_imm,
  output logic              fwd_unit_selector1,
  output logic [1:0]        fwd_unit_selector2,
  output logic [15:0]       fwd_count
);

  pipe_act_e         act_s;
  logic              sel1_s, fwd_event_s;
  logic [1:0]        sel2_s;

  logic              valid_q, valid_d, rw_q, rw_d, sel1_q, sel1_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RIDX_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [1:0]        sel2_q, sel2_d;
  logic [15:0]       cnt_q, cnt_d;

  fwd_detect #(.RIDX_W(RIDX_W)) u_fwd_detect (
    .ex_valid_i     (valid_q),
    .ex_reg_write_i (rw_q),
    .ex_rd_i        (rd_q),
    .rs1_i          (id_rs1),
    .rs2_i          (id_rs2),
    .use_imm_i      (id_use_imm),
    .sel1_o         (sel1_s),
    .sel2_o         (sel2_s),
    .fwd_event_o    (fwd_event_s)
  );

  always_comb begin
    if (pipe_flush) begin
      act_s = ACT_BUBBLE;
    end else if (pipe_hold) begin
      act_s = ACT_HOLD;
    end else if (!id_valid) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    op_d    = op_q;
    rd_d    = rd_q;
    reg1_d  = reg1_q;
    reg2_d  = reg2_q;
    imm_d   = imm_q;
    sel1_d  = sel1_q;
    sel2_d  = sel2_q;
    cnt_d   = cnt_q;
    case (act_s)
      ACT_LOAD: begin
        valid_d = 1'b1;
        rw_d    = id_reg_write;
        op_d    = id_opcode;
        rd_d    = id_rd;
        reg1_d  = id_reg1;
        reg2_d  = id_reg2;
        imm_d   = id_imm;
        sel1_d  = sel1_s;
        sel2_d  = sel2_s;
        cnt_d   = fwd_event_s ? sat_inc(cnt_q) : cnt_q;
      end
      ACT_BUBBLE: begin
        // The forwarding counter survives bubbles.
        valid_d = 1'b0;
        rw_d    = 1'b0;
        op_d    = '0;
        rd_d    = '0;
        reg1_d  = '0;
        reg2_d  = '0;
        imm_d   = '0;
        sel1_d  = SEL1_REG;
        sel2_d  = SEL2_REG;
      end
      ACT_HOLD: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      imm_q   <= '0;
      sel1_q  <= SEL1_REG;
      sel2_q  <= SEL2_REG;
      cnt_q   <= 16'h0000;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      imm_q   <= imm_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_mex_valid       = valid_q;
  assign id_mex_reg_write   = rw_q;
  assign id_mex_opcode      = op_q;
  assign id_mex_rd          = rd_q;
  assign id_mex_reg1        = reg1_q;
  assign id_mex_reg2        = reg2_q;
  assign instr_imm          = imm_q;
  assign fwd_unit_selector1 = sel1_q;
  assign fwd_unit_selector2 = sel2_q;
  assign fwd_count          = cnt_q;

endmodule
